// File: rtl/demux_rr_dispatcher_if.sv
// Bundle of the producer-side and consumer-side handshake signals of the 1-to-4 dispatcher.
// Latency: none, wires only. Backpressure: in_ready mirrors the granted channel's out_ready.
// Ports: slave = dispatcher view, master = producer/consumer/test view.
interface demux_rr_dispatcher_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        chan_en;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [1:0]        sel;
    logic              busy;
    logic              stall_err;

    modport slave (
        input  in_valid, in_data, chan_en, out_ready,
        output in_ready, out_valid, out_data, sel, busy, stall_err
    );

    modport master (
        output in_valid, in_data, chan_en, out_ready,
        input  in_ready, out_valid, out_data, sel, busy, stall_err
    );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Round-robin burst dispatcher: one valid/ready input stream to four consumer channels.
// Latency: datapath combinational while granted; one bubble cycle per grant; stall_err one cycle after abandon.
// Backpressure: in_ready = granted channel's out_ready; a watchdog abandons a burst after STALL_MAX stalled cycles.
// Ports: clk, rst (async active-high), bus (slave modport: in_valid/in_data/in_ready, chan_en,
//        out_valid/out_data/out_ready, sel, busy, stall_err).
module demux_rr_dispatcher #(
    parameter int DATA_W    = 8,
    parameter int BURST     = 4,
    parameter int STALL_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_rr_dispatcher_if.slave   bus
);
    localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int SCW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [1:0]     sel_q;
    logic [1:0]     last_sel;
    logic [BCW-1:0] burst_cnt;
    logic [SCW-1:0] stall_cnt;
    logic           busy_q;
    logic           stall_err_q;

    logic [1:0]     pick;
    logic           pick_vld;
    logic [1:0]     idx;
    logic           xfer;
    logic           stall;
    logic           last_beat;
    logic           stall_last;

    // Scan last_sel+1 .. last_sel+4; walking the offsets downward lets the
    // nearest enabled channel overwrite farther ones. Offset 4 wraps to last_sel.
    always_comb begin
        pick     = last_sel;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = last_sel + 2'(i);
            if (bus.chan_en[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign xfer       = (state == GRANT) && bus.in_valid && bus.out_ready[sel_q];
    assign stall      = (state == GRANT) && bus.in_valid && !bus.out_ready[sel_q];
    assign last_beat  = (burst_cnt == BCW'(BURST - 1));
    assign stall_last = (stall_cnt == SCW'(STALL_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_q       <= 2'd0;
            last_sel    <= 2'd3;
            burst_cnt   <= '0;
            stall_cnt   <= '0;
            busy_q      <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            stall_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && pick_vld) begin
                        sel_q     <= pick;
                        burst_cnt <= '0;
                        stall_cnt <= '0;
                        busy_q    <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + BCW'(1);
                    end
                    // Only consecutive stalls count; a transfer or an idle producer restarts the watchdog.
                    if (stall) begin
                        stall_cnt <= stall_cnt + SCW'(1);
                    end else begin
                        stall_cnt <= '0;
                    end
                    if ((xfer && last_beat) ||
                        (!bus.chan_en[sel_q] && !xfer) ||
                        (stall && stall_last)) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        last_sel <= sel_q;
                        // Disabled-channel exit outranks the watchdog, so no error then.
                        stall_err_q <= stall && stall_last && bus.chan_en[sel_q];
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == GRANT) && bus.out_ready[sel_q];
    assign bus.out_valid = (state == GRANT) ? (4'(bus.in_valid) << sel_q) : 4'b0000;
    assign bus.out_data  = bus.in_data[DATA_W-1:0];
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.stall_err = stall_err_q;
endmodule
